int_claim_arbiter: RTL and testbench
====================================

// Module: int_claim_arbiter
// PURPOSE
//  Interrupt gateway + claim/complete arbiter between the external interrupt
//  sources (DMA, SCtrl, EPU, ...) and the CPU's interrupt-entry logic.
//  - Latches each source into a pending bit and applies a per-source enable mask.
//  - Selects one winner by fixed priority and raises a single request to the CPU.
//  - Runs a claim/complete handshake so that only one interrupt is in service.
//  - A source cannot re-pend until its handler signals completion.
// PARAMETERS
//  N_SRC  4  number of interrupt sources; source k has ID k+1 (ID 0 = none)
//  ID_W   3  width of interrupt IDs; must satisfy 2**ID_W > N_SRC
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst_n          in   1      reset, asynchronous, active-low
//  src_irq_i      in   N_SRC  level-sensitive interrupt lines, bit k = ID k+1
//  src_en_i       in   N_SRC  per-source enable mask (from CSR)
//  claim_i        in   1      CPU takes the interrupt (1-cycle pulse)
//  complete_i     in   1      handler done (1-cycle pulse, e.g. on mret)
//  complete_id_i  in   ID_W   ID being completed
//  irq_o          out  1      interrupt request to CPU
//  claim_id_o     out  ID_W   ID of interrupt in service; 0 when none
//  busy_o         out  1      an interrupt is in service
//  pending_o      out  N_SRC  raw pending bits (CSR readback)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, pending=0, in_service=0, irq_o=0,
//   claim_id_o=0, busy_o=0. Reset mid-operation drops any claimed or pending IRQ.
//  Gateway, per source k, per edge:
//   - pending[k] <= 1 when src_irq_i[k] & ~in_service[k].
//   - pending[k] <= 0 when k is claimed.
//   - pending[k] holds otherwise; it does not clear when the line drops.
//  Eligible set: elig = pending & src_en_i. Winner = highest index set in elig.
//   IDs are 1-based, so the highest ID wins (EPU > SCtrl > DMA_fin > DMA_notify).
//  Masking: clearing src_en_i[k] masks pending[k] but keeps it; re-enabling
//   makes it eligible again.
//  FSM (registered; irq_o = state==NOTIFY; busy_o = state==SERVICE):
//   IDLE:    |elig -> NOTIFY.
//   NOTIFY:  winner is combinational each cycle, so a higher-priority arrival
//            preempts before the claim.
//            - claim_i: claim_id_o <= winner ID, pending[w] <= 0,
//              in_service[w] <= 1, -> SERVICE.
//            - else if elig==0 (all masked): -> IDLE; irq_o falls next cycle.
//   SERVICE: complete_i & complete_id_i==claim_id_o -> in_service cleared,
//            claim_id_o <= 0, -> IDLE.
//            Mismatched complete IDs are ignored.
//  Latency: line sampled high at edge t -> pending after t -> irq_o=1 after t+1.
//   Back-to-back: IDLE after complete -> NOTIFY after one more edge, if elig.
//  Ignored events: claim_i outside NOTIFY; complete_i outside SERVICE.
//  Simultaneous claim_i and elig->0 in NOTIFY: the claim wins only if elig!=0
//   in that cycle; otherwise -> IDLE with no claim.
//  Same-cycle completion and re-assertion of the same source: in_service clears
//   at that edge, so pending sets on the following edge while the line is high.
//  No nesting: at most one in_service bit is ever set.
// TESTING
//  1 Reset: rst_n=0 mid-SERVICE -> irq_o=0, claim_id_o=0, busy_o=0,
//    pending_o=0 immediately.
//  2 Single source: src_irq_i=4'b0001, en=4'hF at edge 0 -> irq_o=1 after
//    edge 1; claim_i -> claim_id_o=1, busy_o=1; complete_id=1 -> IDLE.
//  3 Priority/preempt: bit0 pending, NOTIFY; bit3 rises, then claim_i two
//    cycles later -> claim_id_o=4, pending_o=4'b0001, re-notify after complete.
//  4 Mask: pending 4'b0010, en=0 -> irq_o stays 0; en=4'b0010 -> irq_o=1;
//    drop en in NOTIFY -> IDLE.
//  5 Wrong complete: in service ID 3, complete_id_i=2 -> busy_o stays 1;
//    claim_i in SERVICE ignored.
//  6 Level re-pend: line 2 held high through complete -> pending_o[1]=1 the
//    cycle after completion, irq_o=1 one cycle later.

Source files
------------

// File: rtl/int_claim_arbiter_if.sv
// Interrupt claim/complete bus between the interrupt sources/CPU side and the
// arbiter. Signal directions are named from the arbiter's point of view.
//   src_irq_i     level-sensitive interrupt lines, bit k = ID k+1
//   src_en_i      per-source enable mask
//   claim_i       CPU takes the interrupt (1-cycle pulse)
//   complete_i    handler done (1-cycle pulse)
//   complete_id_i ID being completed
//   irq_o         interrupt request to CPU
//   claim_id_o    ID in service, 0 when none
//   busy_o        an interrupt is in service
//   pending_o     raw pending bits
interface int_claim_arbiter_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
);
  logic [N_SRC-1:0] src_irq_i;
  logic [N_SRC-1:0] src_en_i;
  logic             claim_i;
  logic             complete_i;
  logic [ID_W-1:0]  complete_id_i;
  logic             irq_o;
  logic [ID_W-1:0]  claim_id_o;
  logic             busy_o;
  logic [N_SRC-1:0] pending_o;

  modport slave (
    input  src_irq_i, src_en_i, claim_i, complete_i, complete_id_i,
    output irq_o, claim_id_o, busy_o, pending_o
  );

  modport master (
    output src_irq_i, src_en_i, claim_i, complete_i, complete_id_i,
    input  irq_o, claim_id_o, busy_o, pending_o
  );
endinterface

// File: rtl/int_claim_arbiter.sv
// Interrupt gateway + claim/complete arbiter.
// Latches each source into a pending bit, masks with a per-source enable,
// picks the highest-ID eligible source and runs a claim/complete handshake so
// only one interrupt is in service at a time. A source cannot re-pend until its
// handler completes.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus_io arbiter side of int_claim_arbiter_if (see interface header)
module int_claim_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  int_claim_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NOTIFY  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  claim_id_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;

  logic [N_SRC-1:0] elig;
  logic [ID_W-1:0]  win_id;
  logic [N_SRC-1:0] win_oh;
  logic             claim_fire;
  logic             complete_fire;

  assign elig = pending_q & bus_io.src_en_i;

  // Fixed priority: later (higher) indices overwrite, so the highest ID wins.
  always_comb begin
    win_id = '0;
    win_oh = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (elig[k]) begin
        win_id    = ID_W'(k + 1);
        win_oh    = '0;
        win_oh[k] = 1'b1;
      end
    end
  end

  // A claim only lands if something is still eligible in that same cycle.
  assign claim_fire    = (state_q == NOTIFY) && bus_io.claim_i && (|elig);
  assign complete_fire = (state_q == SERVICE) && bus_io.complete_i &&
                         (bus_io.complete_id_i == claim_id_q);

  // Gateway: the set term looks at the registered in_service, so a source
  // completed this edge can only re-pend on the following edge. The claim
  // clear takes precedence over a same-edge set.
  always_comb begin
    pending_d = pending_q | (bus_io.src_irq_i & ~in_service_q);
    if (claim_fire) pending_d = pending_d & ~win_oh;
  end

  always_comb begin
    in_service_d = in_service_q;
    if (complete_fire)   in_service_d = '0;
    else if (claim_fire) in_service_d = win_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      claim_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig) state_q <= NOTIFY;
        end
        NOTIFY: begin
          if (claim_fire) begin
            claim_id_q <= win_id;
            state_q    <= SERVICE;
          end else if (~|elig) begin
            state_q <= IDLE;
          end
        end
        SERVICE: begin
          if (complete_fire) begin
            claim_id_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          claim_id_q <= '0;
        end
      endcase
    end
  end

  assign bus_io.irq_o      = (state_q == NOTIFY);
  assign bus_io.busy_o     = (state_q == SERVICE);
  assign bus_io.claim_id_o = claim_id_q;
  assign bus_io.pending_o  = pending_q;

endmodule

// File: tb/tb_int_claim_arbiter.sv
module tb_int_claim_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  int_claim_arbiter_if #(.N_SRC(4), .ID_W(3)) bus ();

  int_claim_arbiter #(.N_SRC(4), .ID_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       irq;
    logic [2:0] id;
    logic       busy;
    logic [3:0] pend;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge outputs, advance one edge, then pop and compare.
  task automatic cyc(input string tag, input logic ei, input logic [2:0] eid,
                     input logic eb, input logic [3:0] ep);
    exp_t e;
    exp_t got;
    e.tag = tag; e.irq = ei; e.id = eid; e.busy = eb; e.pend = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb.pop_front();
      check_eq({got.tag, ".irq"},  32'(bus.irq_o),      32'(got.irq));
      check_eq({got.tag, ".id"},   32'(bus.claim_id_o), 32'(got.id));
      check_eq({got.tag, ".busy"}, 32'(bus.busy_o),     32'(got.busy));
      check_eq({got.tag, ".pend"}, 32'(bus.pending_o),  32'(got.pend));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.src_irq_i = '0; bus.src_en_i = 4'hF;
    bus.claim_i = 1'b0; bus.complete_i = 1'b0; bus.complete_id_i = '0;
    #2;
    check_eq("rst.irq",  32'(bus.irq_o),      32'd0);
    check_eq("rst.id",   32'(bus.claim_id_o), 32'd0);
    check_eq("rst.busy", 32'(bus.busy_o),     32'd0);
    check_eq("rst.pend", 32'(bus.pending_o),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single source
    bus.src_irq_i = 4'b0001;
    cyc("t2.pend",   0, 0, 0, 4'b0001);
    bus.src_irq_i = 4'b0000;
    cyc("t2.notify", 1, 0, 0, 4'b0001);
    bus.claim_i = 1'b1;
    cyc("t2.claim",  0, 1, 1, 4'b0000);
    bus.claim_i = 1'b0;
    cyc("t2.svc",    0, 1, 1, 4'b0000);
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd1;
    cyc("t2.done",   0, 0, 0, 4'b0000);
    bus.complete_i = 1'b0;

    // Priority / preemption before the claim
    bus.src_irq_i = 4'b0001;
    cyc("t3.pend",   0, 0, 0, 4'b0001);
    bus.src_irq_i = 4'b0000;
    cyc("t3.notify", 1, 0, 0, 4'b0001);
    bus.src_irq_i = 4'b1000;
    cyc("t3.hi",     1, 0, 0, 4'b1001);
    bus.src_irq_i = 4'b0000;
    cyc("t3.wait",   1, 0, 0, 4'b1001);
    bus.claim_i = 1'b1;
    cyc("t3.claim4", 0, 4, 1, 4'b0001);
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd4;
    cyc("t3.done4",  0, 0, 0, 4'b0001);
    bus.complete_i = 1'b0;
    cyc("t3.renot",  1, 0, 0, 4'b0001);
    bus.claim_i = 1'b1;
    cyc("t3.claim1", 0, 1, 1, 4'b0000);
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd1;
    cyc("t3.done1",  0, 0, 0, 4'b0000);
    bus.complete_i = 1'b0;

    // Masking, unmask, drop enable in NOTIFY, claim racing a mask
    bus.src_en_i = 4'b0000; bus.src_irq_i = 4'b0010;
    cyc("t4.masked", 0, 0, 0, 4'b0010);
    bus.src_irq_i = 4'b0000;
    cyc("t4.hold1",  0, 0, 0, 4'b0010);
    cyc("t4.hold2",  0, 0, 0, 4'b0010);
    bus.src_en_i = 4'b0010;
    cyc("t4.unmask", 1, 0, 0, 4'b0010);
    bus.src_en_i = 4'b0000;
    cyc("t4.drop",   0, 0, 0, 4'b0010);
    bus.src_en_i = 4'b0010;
    cyc("t4.renot",  1, 0, 0, 4'b0010);
    bus.src_en_i = 4'b0000; bus.claim_i = 1'b1;
    cyc("t4.race",   0, 0, 0, 4'b0010);
    bus.claim_i = 1'b0; bus.src_en_i = 4'hF;
    cyc("t4.renot2", 1, 0, 0, 4'b0010);
    bus.claim_i = 1'b1;
    cyc("t4.claim2", 0, 2, 1, 4'b0000);
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd2;
    cyc("t4.done2",  0, 0, 0, 4'b0000);
    bus.complete_i = 1'b0;

    // Wrong complete ID, claim ignored in SERVICE
    bus.src_irq_i = 4'b0100;
    cyc("t5.pend",   0, 0, 0, 4'b0100);
    bus.src_irq_i = 4'b0000;
    cyc("t5.notify", 1, 0, 0, 4'b0100);
    bus.claim_i = 1'b1;
    cyc("t5.claim3", 0, 3, 1, 4'b0000);
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd2;
    cyc("t5.wrongc", 0, 3, 1, 4'b0000);
    bus.complete_i = 1'b0;
    bus.src_irq_i = 4'b0001; bus.claim_i = 1'b1;
    cyc("t5.ignclm", 0, 3, 1, 4'b0001);
    bus.src_irq_i = 4'b0000; bus.claim_i = 1'b0;
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd3;
    cyc("t5.done3",  0, 0, 0, 4'b0001);
    bus.complete_i = 1'b0;
    cyc("t5.renot",  1, 0, 0, 4'b0001);
    bus.claim_i = 1'b1;
    cyc("t5.claim1", 0, 1, 1, 4'b0000);
    bus.claim_i = 1'b0;
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd1;
    cyc("t5.done1",  0, 0, 0, 4'b0000);
    bus.complete_i = 1'b0;

    // Level re-pend of a held line after completion
    bus.src_irq_i = 4'b0010;
    cyc("t6.pend",   0, 0, 0, 4'b0010);
    cyc("t6.notify", 1, 0, 0, 4'b0010);
    bus.claim_i = 1'b1;
    cyc("t6.claim",  0, 2, 1, 4'b0000);
    bus.claim_i = 1'b0;
    cyc("t6.block",  0, 2, 1, 4'b0000);
    bus.complete_i = 1'b1; bus.complete_id_i = 3'd2;
    cyc("t6.done",   0, 0, 0, 4'b0000);
    bus.complete_i = 1'b0;
    cyc("t6.repend", 0, 0, 0, 4'b0010);
    cyc("t6.renot",  1, 0, 0, 4'b0010);
    bus.claim_i = 1'b1;
    cyc("t6.claim2", 0, 2, 1, 4'b0000);
    bus.claim_i = 1'b0;
    bus.src_irq_i = 4'b0101;
    cyc("t6.svc",    0, 2, 1, 4'b0101);

    // Asynchronous reset in the middle of SERVICE
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t1.irq",  32'(bus.irq_o),      32'd0);
    check_eq("t1.id",   32'(bus.claim_id_o), 32'd0);
    check_eq("t1.busy", 32'(bus.busy_o),     32'd0);
    check_eq("t1.pend", 32'(bus.pending_o),  32'd0);
    bus.src_irq_i = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("t1.after",  0, 0, 0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
